// File: rtl/obi_pkg.sv
// OBI request/response types shared by the crossbar, arbiters and slaves.
package obi_pkg;

  localparam int unsigned OBI_AW  = 32;
  localparam int unsigned OBI_DW  = 32;
  localparam int unsigned OBI_BEW = OBI_DW / 8;

  typedef struct packed {
    logic               req;
    logic               we;
    logic [OBI_BEW-1:0] be;
    logic [OBI_AW-1:0]  addr;
    logic [OBI_DW-1:0]  wdata;
  } obi_req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [OBI_DW-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// Ordered record of granted master indices; the head names the owner of the
// next read response. Pushes while full and pops while empty are ignored.
module obi_arb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full      = (cnt_r == CNT_W'(DEPTH));
  assign empty     = (cnt_r == '0);
  assign cnt       = cnt_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/obi_slave_rr_arbiter_chk.sv
// Protocol checks for the OBI round-robin arbiter; simulation only.
module obi_slave_rr_arbiter_chk #(
  parameter int unsigned NUM_MASTERS     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IDX_W           = 2,
  parameter int unsigned CNT_W           = 2
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  input logic                   lock,
  input logic [IDX_W-1:0]       lock_idx,
  input logic [NUM_MASTERS-1:0] req_vec,
  input logic                   push,
  input logic                   full,
  input logic                   rvalid,
  input logic                   empty,
  input logic [CNT_W-1:0]       cnt
);

  a_rvalid_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rvalid && empty));

  // a presented but ungranted request must stay up until it is granted
  a_locked_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock |-> req_vec[lock_idx]);

  a_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && full));

  a_cnt_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/obi_slave_rr_arbiter.sv
// Round-robin sharing of one OBI slave between NUM_MASTERS masters, with
// in-order routing of read responses back to the issuing master.
module obi_slave_rr_arbiter
  import obi_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  obi_req_t  [NUM_MASTERS-1:0] master_req_i,
  output obi_resp_t [NUM_MASTERS-1:0] master_resp_o,
  output obi_req_t                    slave_req_o,
  input  obi_resp_t                   slave_resp_i
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0]       prio_r;
  logic                   lock_r;
  logic [IDX_W-1:0]       lock_idx_r;
  logic [NUM_MASTERS-1:0] req_vec_s;
  logic [IDX_W-1:0]       winner_s;
  logic                   sel_valid_s;
  logic [IDX_W-1:0]       prio_next_s;
  obi_req_t               slave_req_s;
  obi_resp_t [NUM_MASTERS-1:0] master_resp_s;
  logic                   accept_s;
  logic                   pop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [CNT_W-1:0]       fifo_cnt_s;
  logic [IDX_W-1:0]       head_s;

  // gather request bits
  always_comb begin
    req_vec_s = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      req_vec_s[i] = master_req_i[i].req;
    end
  end

  // winner: locked master, else first requester at or above prio (wrapping)
  always_comb begin
    int unsigned cand;
    logic        take;
    cand        = 0;
    take        = 1'b0;
    winner_s    = '0;
    sel_valid_s = 1'b0;
    if (lock_r) begin
      winner_s    = lock_idx_r;
      sel_valid_s = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        cand        = 32'(prio_r) + i;
        cand        = (cand >= NUM_MASTERS) ? cand - NUM_MASTERS : cand;
        take        = !sel_valid_s && req_vec_s[IDX_W'(cand)];
        winner_s    = take ? IDX_W'(cand) : winner_s;
        sel_valid_s = sel_valid_s | req_vec_s[IDX_W'(cand)];
      end
    end
  end

  // forward the winner unless the response FIFO is full
  always_comb begin
    slave_req_s = '0;
    if (!fifo_full_s && sel_valid_s) begin
      slave_req_s = master_req_i[winner_s];
    end else begin
      slave_req_s = '0;
    end
  end

  assign accept_s = slave_req_s.req & slave_resp_i.gnt;
  assign pop_s    = slave_resp_i.rvalid & ~fifo_empty_s;

  // grant goes to the forwarded master, responses to the FIFO head
  always_comb begin
    master_resp_s = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      master_resp_s[m].gnt    = accept_s & (winner_s == IDX_W'(m));
      master_resp_s[m].rvalid = pop_s & (head_s == IDX_W'(m));
      master_resp_s[m].rdata  = master_resp_s[m].rvalid ? slave_resp_i.rdata : '0;
    end
  end

  // next priority position after the current winner
  always_comb begin
    prio_next_s = '0;
    if (winner_s == IDX_W'(NUM_MASTERS - 1)) begin
      prio_next_s = '0;
    end else begin
      prio_next_s = winner_s + 1'b1;
    end
  end

  // pointer and lock state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_r     <= '0;
      lock_r     <= 1'b0;
      lock_idx_r <= '0;
    end else if (accept_s) begin
      prio_r <= prio_next_s;
      lock_r <= 1'b0;
    end else if (slave_req_s.req) begin
      lock_r     <= 1'b1;
      lock_idx_r <= winner_s;
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (accept_s),
    .pop    (pop_s),
    .wdata  (winner_s),
    .rdata  (head_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .cnt    (fifo_cnt_s)
  );

  assign slave_req_o   = slave_req_s;
  assign master_resp_o = master_resp_s;

`ifndef SYNTHESIS
  obi_slave_rr_arbiter_chk #(
    .NUM_MASTERS     (NUM_MASTERS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .IDX_W           (IDX_W),
    .CNT_W           (CNT_W)
  ) u_chk (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .lock     (lock_r),
    .lock_idx (lock_idx_r),
    .req_vec  (req_vec_s),
    .push     (accept_s),
    .full     (fifo_full_s),
    .rvalid   (slave_resp_i.rvalid),
    .empty    (fifo_empty_s),
    .cnt      (fifo_cnt_s)
  );
`endif

endmodule

// File: tb/tb_obi_slave_rr_arbiter.sv
// Directed and randomized bench for obi_slave_rr_arbiter with a queue-based
// reference model of arbitration and response routing.
module tb_obi_slave_rr_arbiter;
  import obi_pkg::*;

  localparam int N   = 4;
  localparam int MAX = 2;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  obi_req_t  [N-1:0] m_req;
  obi_resp_t [N-1:0] m_resp;
  obi_req_t          s_req;
  obi_resp_t         s_resp;

  int checks = 0;
  int errors = 0;

  // reference model state
  int q[$];
  int m_prio = 0;
  bit m_lock = 1'b0;
  int m_lidx = 0;
  int m_win  = 0;
  bit m_fwd  = 1'b0;

  always #5 clk_i = ~clk_i;

  obi_slave_rr_arbiter #(
    .NUM_MASTERS     (N),
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .master_req_i  (m_req),
    .master_resp_o (m_resp),
    .slave_req_o   (s_req),
    .slave_resp_i  (s_resp)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] gnt_vec();
    for (int i = 0; i < N; i++) gnt_vec[i] = m_resp[i].gnt;
  endfunction

  function automatic logic [N-1:0] rv_vec();
    for (int i = 0; i < N; i++) rv_vec[i] = m_resp[i].rvalid;
  endfunction

  function automatic logic [N-1:0] one_hot(input int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic model_check();
    obi_req_t          ereq;
    obi_resp_t [N-1:0] eresp;
    bit found;
    found = 1'b0;
    m_win = 0;
    if (m_lock) begin
      m_win = m_lidx;
      found = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_prio + k) % N;
        if (!found && m_req[c].req) begin
          m_win = c;
          found = 1'b1;
        end
      end
    end
    ereq = '0;
    if (found && q.size() < MAX) ereq = m_req[m_win];
    m_fwd = ereq.req;
    eresp = '0;
    if (m_fwd) eresp[m_win].gnt = s_resp.gnt;
    if (s_resp.rvalid && q.size() > 0) begin
      eresp[q[0]].rvalid = 1'b1;
      eresp[q[0]].rdata  = s_resp.rdata;
    end
    chk("slave_req", 160'(s_req), 160'(ereq));
    chk("master_resp", 160'(m_resp), 160'(eresp));
  endtask

  task automatic model_reset();
    q.delete();
    m_prio = 0;
    m_lock = 1'b0;
    m_lidx = 0;
  endtask

  task automatic model_update();
    if (!rst_ni) begin
      model_reset();
    end else begin
      if (s_resp.rvalid && q.size() > 0) void'(q.pop_front());
      if (m_fwd && s_resp.gnt) begin
        q.push_back(m_win);
        m_prio = (m_win + 1) % N;
        m_lock = 1'b0;
      end else if (m_fwd) begin
        m_lock = 1'b1;
        m_lidx = m_win;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    int ord[6];
    m_req  = '0;
    s_resp = '0;
    model_reset();
    repeat (2) @(negedge clk_i);

    // reset: outputs quiet, stray rvalid routed nowhere
    s_resp.rvalid = 1'b1;
    s_resp.rdata  = 32'h5A5A_5A5A;
    settle();
    chk("reset_slave_req", 160'(s_req), 160'd0);
    chk("reset_rvalid", 160'(rv_vec()), 160'd0);
    tick();
    rst_ni = 1'b1;
    s_resp = '0;
    settle();
    chk("idle_resp", 160'(m_resp), 160'd0);
    tick();

    // single master 2
    m_req[2].req  = 1'b1;
    m_req[2].be   = 4'hF;
    m_req[2].addr = 32'h0000_0100;
    s_resp.gnt    = 1'b1;
    settle();
    chk("single_gnt", 160'(gnt_vec()), 160'(4'b0100));
    chk("single_addr", 160'(s_req.addr), 160'(32'h100));
    tick();
    m_req[2].req  = 1'b0;
    s_resp.gnt    = 1'b0;
    s_resp.rvalid = 1'b1;
    s_resp.rdata  = 32'hDEAD_BEEF;
    settle();
    chk("single_rvalid", 160'(rv_vec()), 160'(4'b0100));
    chk("single_rdata", 160'(m_resp[2].rdata), 160'(32'hDEAD_BEEF));
    tick();

    // all request, no grant: master 3 is next in line and becomes locked
    s_resp = '0;
    for (int i = 0; i < N; i++) begin
      m_req[i].req  = 1'b1;
      m_req[i].addr = 32'h1000 + 32'(4 * i);
      m_req[i].be   = 4'hF;
    end
    settle();
    chk("prio_after_single", 160'(s_req.addr), 160'(32'h100C));
    tick();

    // round robin with grant every cycle
    ord = '{3, 0, 1, 2, 3, 0};
    s_resp.gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s_resp.rvalid = (k > 0);
      s_resp.rdata  = 32'hC0DE_0000 + 32'(k);
      settle();
      chk("rr_gnt", 160'(gnt_vec()), 160'(one_hot(ord[k])));
      if (k > 0) chk("rr_rvalid", 160'(rv_vec()), 160'(one_hot(ord[k-1])));
      tick();
    end
    for (int i = 0; i < N; i++) m_req[i].req = 1'b0;
    s_resp.gnt    = 1'b0;
    s_resp.rvalid = 1'b1;
    settle();
    chk("rr_drain", 160'(rv_vec()), 160'(4'b0001));
    tick();

    // lock: masters 1 and 3, slave withholds gnt
    s_resp = '0;
    m_req[1].req = 1'b1;
    m_req[3].req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("lock_addr", 160'(s_req.addr), 160'(32'h1004));
      chk("lock_nogrant", 160'(gnt_vec()), 160'd0);
      tick();
    end
    s_resp.gnt = 1'b1;
    settle();
    chk("lock_gnt1", 160'(gnt_vec()), 160'(4'b0010));
    tick();
    m_req[1].req  = 1'b0;
    s_resp.rvalid = 1'b1;
    s_resp.rdata  = 32'h11;
    settle();
    chk("lock_gnt3", 160'(gnt_vec()), 160'(4'b1000));
    chk("lock_rv1", 160'(rv_vec()), 160'(4'b0010));
    tick();
    m_req[3].req = 1'b0;
    s_resp.gnt   = 1'b0;
    s_resp.rdata = 32'h33;
    settle();
    chk("lock_rv3", 160'(rv_vec()), 160'(4'b1000));
    tick();

    // full: two accepts, rvalid held off
    s_resp = '0;
    for (int i = 0; i < 3; i++) m_req[i].req = 1'b1;
    s_resp.gnt = 1'b1;
    settle();
    chk("full_acc0", 160'(gnt_vec()), 160'(4'b0001));
    tick();
    m_req[0].req = 1'b0;
    settle();
    chk("full_acc1", 160'(gnt_vec()), 160'(4'b0010));
    tick();
    m_req[1].req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("full_block", 160'(s_req.req), 160'd0);
      tick();
    end
    s_resp.rvalid = 1'b1;
    s_resp.rdata  = 32'hF0;
    settle();
    chk("full_block_pop", 160'(s_req.req), 160'd0);
    chk("full_pop", 160'(rv_vec()), 160'(4'b0001));
    tick();
    s_resp.rvalid = 1'b0;
    settle();
    chk("full_acc2", 160'(gnt_vec()), 160'(4'b0100));
    tick();
    m_req[2].req  = 1'b0;
    s_resp.gnt    = 1'b0;
    s_resp.rvalid = 1'b1;
    settle();
    chk("full_drain1", 160'(rv_vec()), 160'(4'b0010));
    tick();
    settle();
    chk("full_drain2", 160'(rv_vec()), 160'(4'b0100));
    tick();

    // simultaneous push and pop
    s_resp = '0;
    m_req[0].req = 1'b1;
    s_resp.gnt   = 1'b1;
    cyc();
    m_req[0].req  = 1'b0;
    m_req[2].req  = 1'b1;
    s_resp.rvalid = 1'b1;
    s_resp.rdata  = 32'hA0;
    settle();
    chk("simul_rv0", 160'(rv_vec()), 160'(4'b0001));
    chk("simul_gnt2", 160'(gnt_vec()), 160'(4'b0100));
    tick();
    m_req[2].req = 1'b0;
    s_resp.gnt   = 1'b0;
    s_resp.rdata = 32'hA2;
    settle();
    chk("simul_rv2", 160'(rv_vec()), 160'(4'b0100));
    chk("simul_rdata", 160'(m_resp[2].rdata), 160'(32'hA2));
    tick();

    // reset with two outstanding
    s_resp = '0;
    m_req[0].req = 1'b1;
    m_req[1].req = 1'b1;
    s_resp.gnt   = 1'b1;
    cyc();
    m_req[0].req = 1'b0;
    cyc();
    m_req  = '0;
    s_resp = '0;
    rst_ni = 1'b0;
    model_reset();
    s_resp.rvalid = 1'b1;
    settle();
    chk("midrst_slave_req", 160'(s_req), 160'd0);
    chk("midrst_resp", 160'(m_resp), 160'd0);
    tick();
    rst_ni = 1'b1;
    s_resp = '0;
    settle();
    chk("postrst_resp", 160'(m_resp), 160'd0);
    tick();
    for (int i = 0; i < N; i++) m_req[i].req = 1'b1;
    s_resp.gnt = 1'b1;
    settle();
    chk("postrst_prio", 160'(gnt_vec()), 160'(4'b0001));
    tick();
    m_req         = '0;
    s_resp.gnt    = 1'b0;
    s_resp.rvalid = 1'b1;
    cyc();

    // randomized traffic; masters hold requests until granted
    s_resp = '0;
    for (int cy = 0; cy < 800; cy++) begin
      bit granted;
      int w;
      for (int i = 0; i < N; i++) begin
        if (!m_req[i].req && $urandom_range(0, 2) == 0) begin
          m_req[i].req   = 1'b1;
          m_req[i].we    = 1'($urandom());
          m_req[i].be    = 4'($urandom());
          m_req[i].addr  = $urandom();
          m_req[i].wdata = $urandom();
        end
      end
      s_resp.gnt    = 1'($urandom_range(0, 1));
      s_resp.rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      s_resp.rdata  = $urandom();
      settle();
      granted = m_fwd && s_resp.gnt;
      w       = m_win;
      tick();
      if (granted) m_req[w].req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_slave_rr_arbiter.md
# obi_slave_rr_arbiter

Shares one OBI slave port, such as a RAM bank or a peripheral bus, between `NUM_MASTERS` OBI masters using round-robin arbitration. It keeps an ordered record of outstanding transactions so each read-data response (`rvalid`/`rdata`) returns to the master that issued the request. It sits between the master-side ports of the system crossbar and a single slave, and supports pipelined slaves with up to `MAX_OUTSTANDING` accepted-but-unanswered transactions.

## Interface
Parameters:
- `NUM_MASTERS`, default 4: number of requesting masters, at least 2.
- `MAX_OUTSTANDING`, default 2: depth of the response-routing ID FIFO, at least 1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_i`, input, 1: clock.
  - `rst_ni`, input, 1: asynchronous active-low reset.
- `master_req_i`, input, `obi_req_t [NUM_MASTERS-1:0]`: master requests (`req`, `we`, `be`, `addr`, `wdata`).
- `master_resp_o`, output, `obi_resp_t [NUM_MASTERS-1:0]`: per-master `gnt`, `rvalid`, `rdata`.
- `slave_req_o`, output, `obi_req_t`: request forwarded to the shared slave.
- `slave_resp_i`, input, `obi_resp_t`: response from the shared slave.

## Operation
- **State.**
  - Round-robin pointer `prio` (`IDX_W = $clog2(NUM_MASTERS)` bits).
  - Lock flag `lock` and locked index `lock_idx`.
  - ID FIFO of `MAX_OUTSTANDING` entries of `IDX_W` bits, with occupancy counter `cnt` (0 to `MAX_OUTSTANDING`).
- **Winner selection.**
  - If `lock` is set, the winner is `lock_idx`.
  - Otherwise the winner is the first master with `req` set, scanning from `prio` upward modulo `NUM_MASTERS`.
- **Blocking.** When `cnt == MAX_OUTSTANDING` (full):
  - `slave_req_o.req` = 0 and every `gnt` = 0.
  - A pop in the same cycle does not unblock; the block releases the cycle after `cnt` drops.
- **Forwarding.** When not full and some master requests:
  - `slave_req_o` = the winner's request, unchanged.
  - `master_resp_o[winner].gnt` = `slave_resp_i.gnt`.
  - Every other `gnt` = 0.
- **Accept** (`slave_req_o.req & slave_resp_i.gnt`):
  - Push the winner index into the FIFO.
  - `prio` <= winner+1, wrapping from `NUM_MASTERS-1` to 0.
  - Clear `lock`.
- **Lock.** When `slave_req_o.req & !slave_resp_i.gnt`: `lock` <= 1 and `lock_idx` <= winner. This preserves OBI address stability; the arbiter never retracts a presented request.
- **Response.** On `slave_resp_i.rvalid`:
  - Pop the FIFO head `h`.
  - `master_resp_o[h].rvalid` = 1 and `master_resp_o[h].rdata` = `slave_resp_i.rdata`.
  - All other masters get `rvalid` = 0 and `rdata` = 0.
- **Simultaneous accept and rvalid.** Push and pop in the same cycle; `cnt` is unchanged. The pop returns the old head.
- **Error case.** `rvalid` while `cnt == 0` is a protocol error:
  - No master sees `rvalid` and the FIFO does not change.
  - A simulation-only assertion fires.
- **Simulation assertions** (also simulation-only): a locked master dropping `req` before `gnt`; push while full.

## Timing
- Request path and `gnt` path are combinational, with zero added latency.
- `rvalid`/`rdata` routing is combinational from the registered FIFO head, with zero added latency.
- Registered state updates on the rising edge of `clk_i`.
- Reset (`rst_ni` low, asynchronous): `prio` = 0, `lock` = 0, FIFO pointers = 0, `cnt` = 0.
  - With all `master_req_i.req` low and slave `gnt`/`rvalid` low, every output is 0.
- Reset mid-transaction discards all outstanding IDs. Any slave `rvalid` after reset release with `cnt == 0` takes the error case above.
- Sustained throughput is one accept per cycle when the slave grants every cycle and `MAX_OUTSTANDING` ≥ the slave read latency + 1.
- Fairness: a requesting master is granted within `NUM_MASTERS` accepts.

## Structure
- Request/response types come from `obi_pkg`; no new package types.
- `IDX_W` is a local parameter.
- One sub-module, `obi_arb_id_fifo`:
  - Parameters `DEPTH`, `WIDTH`.
  - Ports: push, pop, `wdata`, `rdata`, `full`, `empty`, `cnt`.
  - Same clock and reset polarity as the arbiter.
- The arbiter top holds the pointer, lock, winner selection and response routing.

## Test plan
- **Single master.** After reset, master 2 requests `addr` 0x100; slave `gnt` immediate, `rvalid` next cycle with `rdata` 0xDEADBEEF.
  - Expect `gnt` only on port 2, then `rvalid` only on port 2 with 0xDEADBEEF; `prio` becomes 3.
- **Round-robin.** All 4 masters request continuously; slave grants every cycle.
  - Expect grant order 0, 1, 2, 3, 0, …
  - Expect each `rvalid` to go to the master granted one cycle earlier.
- **Lock.** Masters 1 and 3 request; slave holds `gnt` low for 3 cycles.
  - Expect `slave_req_o.addr` to stay master 1's address throughout and master 3 not granted.
  - On `gnt`: master 1 granted; master 3 granted on the next accept.
- **Full.** `MAX_OUTSTANDING` = 2; slave grants but delays `rvalid` 5 cycles.
  - After 2 accepts, expect `slave_req_o.req` = 0 until the first `rvalid`.
  - Expect the third accept no earlier than the cycle after that pop.
- **Simultaneous push/pop.** With `cnt` = 1 (head = master 0), master 2 is accepted in the same cycle as `rvalid`.
  - Expect `rvalid` to go to master 0, `cnt` to stay 1, and the next `rvalid` to go to master 2.
- **Reset mid-operation.** Assert `rst_ni` low with `cnt` = 2; release.
  - Expect all outputs 0 and `prio` = 0.
  - A stray `rvalid` reaches no master and fires the assertion.
